data_mem_mmio: RTL and testbench
================================

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit RAM words (power of 2).
REQ-002 SHALL have parameter TIMER_W, default 32, timer counter width.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port we  input  1  write strobe from pipeline memory stage (memwriteM).
REQ-006 SHALL have port a  input  32  byte address (aluoutM).
REQ-007 SHALL have port wd  input  32  write data (writedataM).
REQ-008 SHALL have port rd  output  32  read data (readdataM), combinational.
REQ-009 SHALL have port leds  output  8  LED register value.
REQ-010 SHALL have port irq  output  1  timer-expired flag, level.

Function
REQ-011 SHALL decode: a[31:16]==0 -> RAM word a[log2(DEPTH)+1:2]; 0xFFFF0000 LED; 0xFFFF0004 LOAD; 0xFFFF0008 CTRL (bit0 EN, bit1 AUTO); 0xFFFF000C STATUS (bit0 EXP); 0xFFFF0010 COUNT (read-only); all else unmapped.
REQ-012 SHALL ignore a[1:0]; RAM address bits above index ignored within a[15:0] (aliasing).
REQ-013 SHALL return rd in same cycle as a changes (zero-latency read); writes take effect at the next rising edge with we=1.
REQ-014 SHALL return 0 on unmapped reads and ignore unmapped writes and writes to COUNT.
REQ-015 SHALL return LED, LOAD, CTRL zero-extended to 32 bits, STATUS as {31'b0,EXP}, COUNT zero-extended.
REQ-016 SHALL implement timer FSM states IDLE and RUN; IDLE whenever EN=0.
REQ-017 IDLE->RUN on the edge where CTRL is written with EN=1; COUNT <= LOAD on that edge.
REQ-018 In RUN, each edge: COUNT!=0 -> COUNT-1; COUNT==0 -> EXP<=1 and, if AUTO=1, COUNT<=LOAD staying RUN, else EN<=0 and ->IDLE.
REQ-019 Writing LOAD while RUN SHALL set COUNT<=new value on that edge (overrides decrement/expiry).
REQ-020 Writing CTRL with EN=0 SHALL force IDLE on that edge; COUNT holds its value.
REQ-021 Writing STATUS with bit0=1 SHALL clear EXP; if expiry occurs same edge, expiry wins (EXP=1).
REQ-022 irq SHALL equal EXP.
REQ-023 Writing CTRL with EN=1 while already RUN SHALL reload COUNT from LOAD.
REQ-024 Counter arithmetic SHALL be modulo 2^TIMER_W; LOAD=0 expires on first RUN edge after enable.

Reset
REQ-025 On reset edge: leds=0, LOAD=0, CTRL=0, EXP=0, COUNT=0, state IDLE, irq=0.
REQ-026 Reset SHALL NOT alter RAM contents; reset has priority over a simultaneous write.
REQ-027 Reset mid-count SHALL abort the timer with no EXP set.

Structure
REQ-028 Shared package SHALL hold MMIO address constants, CTRL/STATUS bit positions, and timer state enum.
REQ-029 Timer (LOAD/CTRL/STATUS/COUNT, FSM) SHALL be sub-module mmio_timer; RAM and decode in top.

Verification
REQ-030 Write 0xDEADBEEF to 0x00000010, read 0x00000010 and 0x00000013 -> rd=0xDEADBEEF both; read 0x00000014 unwritten-then-written 0x1 -> 0x1.
REQ-031 Write 0xA5 to 0xFFFF0000 -> leds=0xA5 next edge; read 0xFFFF0020 -> rd=0; write 0x123 to 0xFFFF0010 -> COUNT unchanged.
REQ-032 LOAD=3, CTRL=1 -> COUNT 3,2,1,0 on successive edges, EXP/irq=1 on 5th edge after CTRL write, state IDLE, CTRL reads 0.
REQ-033 LOAD=2, CTRL=3 -> irq every 3 cycles, COUNT reloads to 2; STATUS write 1 on expiry edge -> irq stays 1.
REQ-034 LOAD=10 running at COUNT=4, write LOAD=7 -> COUNT=7 next edge, expiry 8 edges later.
REQ-035 Reset asserted at COUNT=5 -> all registers 0, irq=0, RAM word previously 0xDEADBEEF still reads 0xDEADBEEF.

Source files
------------

// File: rtl/data_mem_mmio_pkg.sv
// rtl/data_mem_mmio_pkg.sv - shared MMIO map, register bit positions and timer state type
// Purpose: constants and types shared by data_mem_mmio and mmio_timer.
// Contents: MMIO word addresses, CTRL/STATUS bit positions, timer FSM state enum.
package data_mem_mmio_pkg;

    localparam logic [31:0] ADDR_LED    = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_LOAD   = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_CTRL   = 32'hFFFF_0008;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_000C;
    localparam logic [31:0] ADDR_COUNT  = 32'hFFFF_0010;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AUTO_BIT  = 1;
    localparam int STATUS_EXP_BIT = 0;

    typedef enum logic {
        TIMER_IDLE = 1'b0,
        TIMER_RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - down-counting timer with LOAD/CTRL/STATUS/COUNT registers
// Purpose: programmable timer; one-shot or auto-reload, sets a sticky expiry flag.
// Ports: clk, reset (sync active-high), load_we/ctrl_we/status_we (decoded write
//        strobes), wd (write data), load, ctrl, exp, count (register values).
module mmio_timer
    import data_mem_mmio_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_we,
    input  logic               ctrl_we,
    input  logic               status_we,
    input  logic [31:0]        wd,
    output logic [TIMER_W-1:0] load,
    output logic [1:0]         ctrl,
    output logic               exp,
    output logic [TIMER_W-1:0] count
);

    timer_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            load  <= '0;
            ctrl  <= '0;
            exp   <= 1'b0;
            count <= '0;
            state <= TIMER_IDLE;
        end else begin
            // Clear is placed first so a same-edge expiry below overrides it.
            if (status_we && wd[STATUS_EXP_BIT]) begin
                exp <= 1'b0;
            end

            if (ctrl_we) begin
                ctrl <= wd[1:0];
                if (wd[CTRL_EN_BIT]) begin
                    state <= TIMER_RUN;
                    count <= load;
                end else begin
                    state <= TIMER_IDLE;
                end
            end else if (load_we) begin
                load <= wd[TIMER_W-1:0];
                // A new LOAD while running restarts the count and skips this edge's step.
                if (state == TIMER_RUN) begin
                    count <= wd[TIMER_W-1:0];
                end
            end else if (state == TIMER_RUN) begin
                if (count != '0) begin
                    count <= count - TIMER_W'(1);
                end else begin
                    exp <= 1'b1;
                    if (ctrl[CTRL_AUTO_BIT]) begin
                        count <= load;
                    end else begin
                        ctrl[CTRL_EN_BIT] <= 1'b0;
                        state             <= TIMER_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - data RAM with memory-mapped LED register and timer
// Purpose: pipeline data memory; a[31:16]==0 selects RAM, 0xFFFF00xx selects MMIO.
// Ports: clk, reset (sync active-high), we, a (byte address), wd (write data),
//        rd (combinational read data), leds (LED register), irq (timer expired).
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [7:0]  leds,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]        mem [DEPTH];
    logic [31:0]        word_addr;
    logic [AW-1:0]      idx;
    logic               is_ram;
    logic [TIMER_W-1:0] load;
    logic [TIMER_W-1:0] count;
    logic [1:0]         ctrl;
    logic               exp;

    // Byte lane bits are dropped so any byte address hits its word register.
    assign word_addr = {a[31:2], a[1:0] & 2'b00};
    assign is_ram    = (a[31:16] == 16'h0000);
    // Address bits between the index and bit 15 are ignored, so RAM aliases.
    assign idx       = a[AW+1:2];

    // RAM has no reset; reset still blocks writes so it wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (!reset && we && is_ram) begin
            mem[idx] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds <= '0;
        end else if (we && word_addr == ADDR_LED) begin
            leds <= wd[7:0];
        end
    end

    mmio_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_we   (we && word_addr == ADDR_LOAD),
        .ctrl_we   (we && word_addr == ADDR_CTRL),
        .status_we (we && word_addr == ADDR_STATUS),
        .wd        (wd),
        .load      (load),
        .ctrl      (ctrl),
        .exp       (exp),
        .count     (count)
    );

    assign irq = exp;

    always_comb begin
        rd = '0;
        if (is_ram) begin
            rd = mem[idx];
        end else begin
            case (word_addr)
                ADDR_LED:    rd = {24'h0, leds};
                ADDR_LOAD:   rd = 32'(load);
                ADDR_CTRL:   rd = {30'h0, ctrl};
                ADDR_STATUS: rd = {31'h0, exp};
                ADDR_COUNT:  rd = 32'(count);
                default:     rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb/tb_data_mem_mmio.sv - self-checking bench for data_mem_mmio
module tb_data_mem_mmio;

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_LOAD   = 32'hFFFF_0004;
    localparam logic [31:0] A_CTRL   = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;
    localparam logic [31:0] A_COUNT  = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  leds;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [7:0]  exp_leds;
    } vec_t;

    vec_t vecs[16];

    data_mem_mmio #(
        .DEPTH   (64),
        .TIMER_W (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .leds  (leds),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        a  = addr;
        wd = data;
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [31:0] addr, input logic [31:0] expv);
        a = addr;
        #1;
        chk(name, rd, expv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         8'h00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 8'h00};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 8'h00};
        vecs[3]  = '{1'b1, 32'h0000_0014, 32'h0000_0001, 32'h0,         8'h00};
        vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,         32'h0000_0001, 8'h00};
        vecs[5]  = '{1'b1, A_LED,         32'h0000_00A5, 32'h0,         8'hA5};
        vecs[6]  = '{1'b0, A_LED,         32'h0,         32'h0000_00A5, 8'hA5};
        vecs[7]  = '{1'b0, 32'hFFFF_0020, 32'h0,         32'h0,         8'hA5};
        vecs[8]  = '{1'b1, A_COUNT,       32'h0000_0123, 32'h0,         8'hA5};
        vecs[9]  = '{1'b0, A_COUNT,       32'h0,         32'h0,         8'hA5};
        vecs[10] = '{1'b0, 32'h0000_0110, 32'h0,         32'hDEAD_BEEF, 8'hA5};
        vecs[11] = '{1'b1, 32'h0001_0010, 32'h0000_0055, 32'h0,         8'hA5};
        vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 8'hA5};
        vecs[13] = '{1'b1, A_LOAD + 32'd2, 32'h0000_1234, 32'h0,        8'hA5};
        vecs[14] = '{1'b0, A_LOAD,        32'h0,         32'h0000_1234, 8'hA5};
        vecs[15] = '{1'b1, A_LED,         32'h0000_01FF, 32'h0,         8'hFF};

        reset = 1'b1;
        we    = 1'b0;
        a     = 32'h0;
        wd    = 32'h0;
        step();
        step();
        reset = 1'b0;
        chk("reset_leds", {24'h0, leds}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        rdchk("reset_load", A_LOAD, 32'h0);
        rdchk("reset_ctrl", A_CTRL, 32'h0);
        rdchk("reset_count", A_COUNT, 32'h0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_write) begin
                wr(vecs[i].addr, vecs[i].data);
                chk($sformatf("vec%0d_leds", i), {24'h0, leds}, {24'h0, vecs[i].exp_leds});
            end else begin
                rdchk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
            end
        end

        // One-shot: LOAD=3, EN=1
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'h1);
        rdchk("os_count3", A_COUNT, 32'd3);
        step();
        rdchk("os_count2", A_COUNT, 32'd2);
        step();
        rdchk("os_count1", A_COUNT, 32'd1);
        step();
        rdchk("os_count0", A_COUNT, 32'd0);
        chk("os_irq_before", {31'h0, irq}, 32'h0);
        step();
        chk("os_irq_exp", {31'h0, irq}, 32'h1);
        rdchk("os_ctrl_cleared", A_CTRL, 32'h0);
        rdchk("os_status", A_STATUS, 32'h1);
        step();
        rdchk("os_count_idle", A_COUNT, 32'd0);

        // Auto-reload: LOAD=2, EN|AUTO
        wr(A_STATUS, 32'h1);
        chk("ar_irq_cleared", {31'h0, irq}, 32'h0);
        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'h3);
        rdchk("ar_count2", A_COUNT, 32'd2);
        step();
        chk("ar_irq_e1", {31'h0, irq}, 32'h0);
        step();
        rdchk("ar_count0", A_COUNT, 32'd0);
        chk("ar_irq_e2", {31'h0, irq}, 32'h0);
        step();
        chk("ar_irq_e3", {31'h0, irq}, 32'h1);
        rdchk("ar_reload", A_COUNT, 32'd2);
        wr(A_STATUS, 32'h1);
        chk("ar_irq_clr", {31'h0, irq}, 32'h0);
        rdchk("ar_count1", A_COUNT, 32'd1);
        step();
        wr(A_STATUS, 32'h1);
        chk("ar_exp_wins", {31'h0, irq}, 32'h1);
        rdchk("ar_reload2", A_COUNT, 32'd2);
        wr(A_CTRL, 32'h0);
        rdchk("ar_stop_hold", A_COUNT, 32'd2);
        step();
        rdchk("ar_idle_hold", A_COUNT, 32'd2);

        // LOAD=0 expires on the first run edge
        wr(A_STATUS, 32'h1);
        wr(A_LOAD, 32'd0);
        wr(A_CTRL, 32'h1);
        chk("z_irq_before", {31'h0, irq}, 32'h0);
        step();
        chk("z_irq", {31'h0, irq}, 32'h1);
        rdchk("z_ctrl", A_CTRL, 32'h0);

        // LOAD rewrite while running
        wr(A_STATUS, 32'h1);
        wr(A_LOAD, 32'd10);
        wr(A_CTRL, 32'h1);
        repeat (6) step();
        rdchk("lw_count4", A_COUNT, 32'd4);
        wr(A_LOAD, 32'd7);
        rdchk("lw_count7", A_COUNT, 32'd7);
        repeat (7) step();
        rdchk("lw_count0", A_COUNT, 32'd0);
        chk("lw_irq_before", {31'h0, irq}, 32'h0);
        step();
        chk("lw_irq", {31'h0, irq}, 32'h1);

        // Reset mid-count, with a simultaneous LED write
        wr(A_STATUS, 32'h1);
        wr(A_LOAD, 32'd10);
        wr(A_CTRL, 32'h1);
        repeat (5) step();
        rdchk("rs_count5", A_COUNT, 32'd5);
        reset = 1'b1;
        a     = A_LED;
        wd    = 32'h0000_0033;
        we    = 1'b1;
        step();
        reset = 1'b0;
        we    = 1'b0;
        chk("rs_leds", {24'h0, leds}, 32'h0);
        chk("rs_irq", {31'h0, irq}, 32'h0);
        rdchk("rs_load", A_LOAD, 32'h0);
        rdchk("rs_ctrl", A_CTRL, 32'h0);
        rdchk("rs_count", A_COUNT, 32'h0);
        rdchk("rs_ram", 32'h0000_0010, 32'hDEAD_BEEF);
        repeat (12) step();
        chk("rs_irq_later", {31'h0, irq}, 32'h0);
        rdchk("rs_count_later", A_COUNT, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
